// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V instruction fetch path.
package riscv_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE      = 3'd0,
        FETCH_ADDR      = 3'd1,
        FETCH_DATA      = 3'd2,
        FETCH_DROP_ADDR = 3'd3,
        FETCH_DROP_DATA = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0] AXI_ARPROT_INSTR = 3'b100;

endpackage

// File: rtl/riscv_instr_fetch_axil.sv
// AXI4-Lite read master fetching one instruction per request, with flush
// support that drains in-flight transactions instead of abandoning them.
module riscv_instr_fetch_axil
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i_read_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    input  logic                   i_flush,
    output logic                   o_fetch_ready,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_fetch_err,
    output logic                   o_busy,
    output logic [ADDR_WIDTH-1:0]  m_axil_araddr,
    output logic [2:0]             m_axil_arprot,
    output logic                   m_axil_arvalid,
    input  logic                   m_axil_arready,
    input  logic [INSTR_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]             m_axil_rresp,
    input  logic                   m_axil_rvalid,
    output logic                   m_axil_rready
);

    fetch_state_t           state_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic                   arvalid_q;
    logic                   rready_q;
    logic                   instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   fetch_err_q;
    logic                   resp_err;

    assign resp_err = (m_axil_rresp == AXI_RESP_SLVERR) || (m_axil_rresp == AXI_RESP_DECERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= RISCV_NOP;
            fetch_err_q   <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                FETCH_IDLE: begin
                    if (enable && i_read_instr && !i_flush) begin
                        if (i_pc[1:0] == 2'b00) begin
                            araddr_q  <= i_pc;
                            arvalid_q <= 1'b1;
                            state_q   <= FETCH_ADDR;
                        end else begin
                            // Misaligned PC is reported without touching the bus.
                            instr_valid_q <= 1'b1;
                            fetch_err_q   <= 1'b1;
                            instr_q       <= RISCV_NOP;
                        end
                    end
                end
                FETCH_ADDR: begin
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= i_flush ? FETCH_DROP_DATA : FETCH_DATA;
                    end else if (i_flush) begin
                        state_q <= FETCH_DROP_ADDR;
                    end
                end
                FETCH_DROP_ADDR: begin
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= FETCH_DROP_DATA;
                    end
                end
                FETCH_DATA: begin
                    if (m_axil_rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= FETCH_IDLE;
                        if (!i_flush) begin
                            instr_valid_q <= 1'b1;
                            instr_q       <= m_axil_rdata;
                            fetch_err_q   <= resp_err;
                        end
                    end else if (i_flush) begin
                        state_q <= FETCH_DROP_DATA;
                    end
                end
                FETCH_DROP_DATA: begin
                    if (m_axil_rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= FETCH_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign o_fetch_ready  = (state_q == FETCH_IDLE) && enable;
    assign o_busy         = (state_q != FETCH_IDLE);
    assign o_instr_valid  = instr_valid_q;
    assign o_instr        = instr_q;
    assign o_fetch_err    = fetch_err_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = AXI_ARPROT_INSTR;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule
